bus_dma_master: RTL and testbench

- Bus-master engine that copies a block of 32-bit words from one slave address range to another.
- Plugs into a master port (M0 or M1) of the two-master/two-slave shared bus, directly upstream of the arbiter/decoder.
- Software-free: the transfer is launched by a start pulse with source, destination and length.
- Holds its bus request for the whole transfer, then pulses done.

---
 rtl/bus_pkg.sv | 28 ++
 rtl/bus_dma_master.sv | 149 ++++++++++++++
 tb/tb_bus_dma_master.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master/two-slave bus and the DMA master:
// FSM encodings, slave address map and default bus widths.
package bus_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  localparam logic [7:0] S0_BASE  = 8'h00;
  localparam logic [7:0] S1_BASE  = 8'h20;
  localparam logic [7:0] WIN_SIZE = 8'h20;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_RD_ADDR = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_WR      = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    REQ     = ST_REQ,
    RD_ADDR = ST_RD_ADDR,
    RD_WAIT = ST_RD_WAIT,
    WR      = ST_WR,
    DONE    = ST_DONE
  } dma_state_e;

endpackage

// File: rtl/bus_dma_master.sv
// Bus-master block copy engine: reads words from src.., writes them to dst..,
// holding the bus request for the whole transfer and pulsing done at the end.
module bus_dma_master
  import bus_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [7:0]        length,
  output logic              busy,
  output logic              done,
  output logic              M_req,
  output logic              M_wr,
  output logic [ADDR_W-1:0] M_address,
  output logic [DATA_W-1:0] M_dout,
  input  logic              M_grant,
  input  logic [DATA_W-1:0] M_din
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [7:0]        len_q, len_d, idx_q, idx_d;
  logic [1:0]        lat_q, lat_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d, done_q, done_d, req_q, req_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      lat_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != 8'd0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            len_d   = length;
            idx_d   = 8'd0;
            state_d = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (M_grant) state_d = RD_ADDR;
      end
      RD_ADDR: begin
        if (M_grant) begin
          lat_d   = 2'(RD_LATENCY);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Losing the bus mid-read invalidates the pending data; reissue the same word.
        if (!M_grant) begin
          state_d = RD_ADDR;
        end else if (lat_q == 2'd1) begin
          data_d  = M_din;
          state_d = WR;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      WR: begin
        if (M_grant) begin
          idx_d   = idx_q + 8'd1;
          state_d = (idx_q + 8'd1 == len_q) ? DONE : RD_ADDR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered copies of what the next state will drive.
  always_comb begin
    req_d  = (state_d == REQ) || (state_d == RD_ADDR) ||
             (state_d == RD_WAIT) || (state_d == WR);
    wr_d   = (state_d == WR);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    addr_d = '0;
    dout_d = '0;
    if (state_d == WR) begin
      addr_d = dst_d + ADDR_W'(idx_d);
      dout_d = data_d;
    end else if ((state_d == RD_ADDR) || (state_d == RD_WAIT)) begin
      addr_d = src_d + ADDR_W'(idx_d);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign M_req     = req_q;
  assign M_wr      = wr_q;
  assign M_address = addr_q;
  assign M_dout    = dout_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: behavioural bus with a flat slave memory, directed
// vector table, hand-written reset sequence and randomized transfers.
module tb_bus_dma_master;

  localparam int RDL = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  src_addr, dst_addr, length;
  logic        busy, done, M_req, M_wr, M_grant;
  logic [7:0]  M_address;
  logic [31:0] M_dout, M_din;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] pipe [RDL];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic [7:0] stall_addr;
    int         stall_n;
    int         restart_at;
    int         exp_cyc;
  } vec_t;

  vec_t vt [6];

  bus_dma_master #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(RDL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done),
    .M_req(M_req), .M_wr(M_wr), .M_address(M_address), .M_dout(M_dout),
    .M_grant(M_grant), .M_din(M_din)
  );

  always #5 clk = ~clk;

  // Bus plus slaves: granted writes land in memory, granted reads return RDL cycles later.
  always @(posedge clk) begin
    if (M_req && M_grant && M_wr) mem[M_address] <= M_dout;
    pipe[0] <= (M_req && M_grant && !M_wr) ? mem[M_address] : 32'hDEAD_BEEF;
    for (int k = 1; k < RDL; k++) pipe[k] <= pipe[k-1];
  end
  assign M_din = pipe[RDL-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic snapshot();
    for (int a = 0; a < 256; a++) ref_mem[a] = mem[a];
  endtask

  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) ref_mem[8'(d + 8'(i))] = ref_mem[8'(s + 8'(i))];
  endtask

  task automatic cmp_mem(input string nm);
    int bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
    chk(nm, 64'(bad), 64'd0);
  endtask

  task automatic run_xfer(input vec_t v, input bit rnd, output int cyc);
    int se = -1;
    bit req_gap = 1'b0;
    bit busy_gap = 1'b0;
    @(negedge clk);
    start = 1'b1; src_addr = v.src; dst_addr = v.dst; length = v.len;
    M_grant = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    @(posedge clk);
    cyc = 0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      if (v.restart_at >= 0 && cyc == v.restart_at + 1) chk("busy_after_restart", 64'(busy), 64'd1);
      if (v.restart_at >= 0 && cyc == v.restart_at) begin
        start = 1'b1; src_addr = 8'h55; dst_addr = 8'h66; length = 8'h00;
      end
      if (done) break;
      if (cyc > 2000) begin
        n_chk++; n_fail++;
        $display("FAIL timeout: no done after %0d cycles, expected by %0d", cyc, v.exp_cyc);
        break;
      end
      if (!M_req) req_gap = 1'b1;
      if (!busy) busy_gap = 1'b1;
      if (se < 0 && v.stall_n > 0 && M_wr && M_address == v.stall_addr) se = 0;
      if (se > 0 && se <= v.stall_n) begin
        chk("stall_hold_addr", 64'(M_address), 64'(v.stall_addr));
        chk("stall_hold_wr", 64'(M_wr), 64'd1);
      end
      if (se >= 0 && se < v.stall_n) M_grant = 1'b0;
      else M_grant = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (se >= 0 && se <= v.stall_n) se++;
      @(posedge clk);
      cyc++;
    end
    if (v.len != 0) chk("req_held", 64'(req_gap), 64'd0);
    chk("busy_held", 64'(busy_gap), 64'd0);
    chk("done_req", 64'(M_req), 64'd0);
    chk("done_wr", 64'(M_wr), 64'd0);
    chk("done_addr", 64'(M_address), 64'd0);
    chk("done_dout", 64'(M_dout), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    vec_t v;
    bit   done_seen;

    vt[0] = '{8'h00, 8'h20, 8'd4,   8'h00, 0, -1, 13};
    vt[1] = '{8'h10, 8'h30, 8'd0,   8'h00, 0, -1, 0};
    vt[2] = '{8'h0A, 8'h2A, 8'd3,   8'h2B, 3, -1, 13};
    vt[3] = '{8'hFE, 8'h10, 8'd3,   8'h00, 0, 4,  10};
    vt[4] = '{8'h00, 8'h02, 8'd5,   8'h00, 0, -1, 16};
    vt[5] = '{8'h40, 8'h80, 8'd255, 8'h00, 0, -1, 766};

    for (int a = 0; a < 256; a++) mem[a] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    pipe[0] = '0;
    reset_n = 1'b0; start = 1'b0; M_grant = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req", 64'(M_req), 64'd0);
    chk("rst_wr", 64'(M_wr), 64'd0);
    chk("rst_addr", 64'(M_address), 64'd0);
    chk("rst_dout", 64'(M_dout), 64'd0);

    for (int i = 0; i < 6; i++) begin
      snapshot();
      model_copy(vt[i].src, vt[i].dst, int'(vt[i].len));
      run_xfer(vt[i], 1'b0, cyc);
      chk($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vt[i].exp_cyc));
      cmp_mem($sformatf("vec%0d_mem", i));
      if (i == 0)
        for (int k = 0; k < 4; k++)
          chk($sformatf("basic_s1_%0d", k), 64'(mem[8'h20 + k]), 64'(32'h11 * (k + 1)));
    end

    // Reset during the read of the third word: two words copied, no done pulse.
    snapshot();
    model_copy(8'h08, 8'h28, 2);
    @(negedge clk);
    start = 1'b1; src_addr = 8'h08; dst_addr = 8'h28; length = 8'd4; M_grant = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("midrst_rdwait_addr", 64'(M_address), 64'h0A);
    chk("midrst_rdwait_wr", 64'(M_wr), 64'd0);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_req", 64'(M_req), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_addr", 64'(M_address), 64'd0);
    reset_n = 1'b1;
    done_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      done_seen |= done;
    end
    chk("midrst_no_done", 64'(done_seen), 64'd0);
    cmp_mem("midrst_partial_mem");
    v = '{8'h08, 8'h28, 8'd4, 8'h00, 0, -1, 13};
    snapshot();
    model_copy(v.src, v.dst, int'(v.len));
    run_xfer(v, 1'b0, cyc);
    chk("postrst_cycles", 64'(cyc), 64'd13);
    cmp_mem("postrst_mem");

    // Random transfers under random grant.
    for (int r = 0; r < 8; r++) begin
      v.src = 8'($urandom); v.dst = 8'($urandom); v.len = 8'($urandom_range(1, 16));
      v.stall_addr = 8'h00; v.stall_n = 0; v.restart_at = -1;
      v.exp_cyc = 3 * int'(v.len) + 1;
      snapshot();
      model_copy(v.src, v.dst, int'(v.len));
      run_xfer(v, 1'b1, cyc);
      chk($sformatf("rnd%0d_min_cycles", r), 64'(cyc >= v.exp_cyc), 64'd1);
      cmp_mem($sformatf("rnd%0d_mem", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
